mmio_timer_mem: RTL
===================

MMIO_TIMER_MEM -- requirements
Module: mmio_timer_mem

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, meaning the data RAM depth in 32-bit words (power of 2, 16..1024).
REQ-002 SHALL have parameter NUM_TIMERS, default 2, meaning the number of timer channels (1..4).
REQ-003 SHALL have parameter PERIPH_BASE, default 32'h40000000, meaning the base address of the peripheral window.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port addr, input, 32 bits: byte address, word-aligned; addr[1:0] is ignored.
REQ-007 SHALL have port wdata, input, 32 bits: write data.
REQ-008 SHALL have ports rd and wr, input, 1 bit each: read strobe and write strobe.
REQ-009 SHALL have port switch, input, 8 bits: board switch inputs.
REQ-010 SHALL have port rdata, output, 32 bits: read data.
REQ-011 SHALL have port led, output, 8 bits: LED register.
REQ-012 SHALL have port digi, output, 12 bits: 7-segment register.
REQ-013 SHALL have port irq_vec, output, NUM_TIMERS bits: per-channel pending interrupts.
REQ-014 SHALL have port irqout, output, 1 bit: OR of irq_vec.
REQ-015 SHALL have port irq_rise, output, 1 bit: one-cycle pulse on each 0->1 transition of irqout.

Function
REQ-016 SHALL decode the address map as follows:
- addr < PERIPH_BASE: RAM word addr[31:2], valid only when the index < RAM_WORDS.
- PERIPH_BASE+0x20*k+{0x0,0x4,0x8}: TH[k], TL[k], TCON[k], for k < NUM_TIMERS.
- PERIPH_BASE+{0x80,0x84,0x88,0x8C}: led, switch, digi, IRQ_STATUS.
REQ-017 SHALL return rdata combinationally:
- 0 when rd=0.
- Zero-extended register contents when rd=1.
- 0 for unmapped addresses, out-of-range RAM indices, and timer channels k >= NUM_TIMERS.
REQ-018 SHALL perform writes on the rising clk edge when wr=1. Writes to switch, IRQ_STATUS, unmapped addresses and out-of-range RAM indices are silently ignored.
REQ-019 SHALL use this TCON[k] bit map: bit0 EN, bit1 IE, bit2 PEND, bit3 ONESHOT; bits 31:4 read as 0.
REQ-020 SHALL update TCON on write as follows: EN, IE and ONESHOT take wdata; PEND is write-1-to-clear (wdata[2]=1 clears it, 0 leaves it unchanged).
REQ-021 SHALL, per channel, each cycle with EN=1, set TL <= TL+1 when TL != 32'hFFFFFFFF; when TL == 32'hFFFFFFFF, set TL <= TH (overflow event).
REQ-022 SHALL, on an overflow event, set PEND if IE=1 and clear EN if ONESHOT=1.
REQ-023 SHALL, when EN=0, hold TL.
REQ-024 SHALL resolve simultaneous events as follows:
- A bus write to TL in the same cycle as an overflow takes priority: TL <= wdata.
- A PEND clear in the same cycle as an overflow that sets PEND leaves PEND=1.
- A bus write to EN in the same cycle as a one-shot overflow takes priority.
REQ-025 SHALL drive irq_vec[k] = PEND[k] and irqout = |irq_vec. IRQ_STATUS reads {zero-extended irq_vec}.
REQ-026 SHALL generate irq_rise from a registered copy of irqout: irq_rise = irqout & ~irqout_q, asserted exactly 1 cycle per rising transition.
REQ-027 SHALL give RAM reads zero latency (same-cycle data). A write followed by a read of the same word on the next cycle returns the new data.

Reset
REQ-028 SHALL, while reset=0, asynchronously clear all of the following to 0: RAM, TH, TL, TCON, led, digi, irqout_q.
REQ-029 SHALL, during and immediately after reset, drive rdata=0 (when rd=0), irq_vec=0, irqout=0 and irq_rise=0.
REQ-030 SHALL, on reset asserted mid-count, return every timer to idle (EN=0) with PEND lost.

Verification
REQ-031 SHALL be verified with: write RAM[5]=0xDEADBEEF, then read addr 0x14 with rd=1 -> 0xDEADBEEF; read with rd=0 -> 0.
REQ-032 SHALL be verified with: TH0=0xFFFFFFF0, TL0=0xFFFFFFFE, TCON0=0x3 -> PEND set 2 cycles later; TL0=0xFFFFFFF0; irq_rise high exactly 1 cycle; irqout=1.
REQ-033 SHALL be verified with: a one-shot timer (TCON=0xB) overflow -> EN reads 0 and TL holds TH; writing TCON=0x4 -> PEND=0 and irqout=0.
REQ-034 SHALL be verified with: an overflow cycle coincident with a TL write of 0x100 -> TL=0x100; coincident PEND clear -> PEND remains 1.
REQ-035 SHALL be verified with: a RAM write to index RAM_WORDS -> no RAM change and read returns 0; a write to timer index NUM_TIMERS -> ignored.
REQ-036 SHALL be verified with: reset pulsed while 2 timers run with PEND=1 -> all registers 0, irqout=0; switch=0xA5 read at 0x84 -> 0xA5.

Source files
------------

// File: rtl/mmio_timer_mem.sv
// Memory-mapped SoC slice: zero-latency data RAM, up to four 32-bit reload timers
// with interrupt pending bits, and LED / switch / 7-segment registers.
module mmio_timer_mem #(
    parameter int          RAM_WORDS   = 256,
    parameter int          NUM_TIMERS  = 2,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [7:0]            switch,
    output logic [31:0]           rdata,
    output logic [7:0]            led,
    output logic [11:0]           digi,
    output logic [NUM_TIMERS-1:0] irq_vec,
    output logic                  irqout,
    output logic                  irq_rise
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0] ram [RAM_WORDS];
    // Timer state is always sized for four channels; unbuilt channels never
    // accept writes, so they stay zero and read back as zero.
    logic [31:0] th [4];
    logic [31:0] tl [4];
    logic [3:0]  en, ie, pend, oneshot;
    logic        irqout_q;

    logic [31:0]   off;
    logic          is_ram, is_tmr, is_io;
    logic [1:0]    tsel, io_sel;
    logic [2:0]    rsel;
    logic [AW-1:0] ram_idx;
    logic [3:0]    ovf, wr_th, wr_tl, wr_tc;
    logic          unused_off;

    assign off        = addr - PERIPH_BASE;
    assign is_ram     = (addr < PERIPH_BASE) && (addr[31:2] < 30'(RAM_WORDS));
    assign is_tmr     = (addr >= PERIPH_BASE) && (off[31:7] == '0);
    assign is_io      = (addr >= PERIPH_BASE) && (off[31:4] == 28'h8);
    assign tsel       = off[6:5];
    assign rsel       = off[4:2];
    assign io_sel     = off[3:2];
    assign ram_idx    = addr[AW+1:2];
    assign unused_off = &{1'b0, off[1:0]};

    always_comb begin
        ovf   = '0;
        wr_th = '0;
        wr_tl = '0;
        wr_tc = '0;
        for (int k = 0; k < 4; k++) begin
            ovf[k]   = en[k] && (tl[k] == 32'hFFFF_FFFF);
            wr_th[k] = wr && is_tmr && (k < NUM_TIMERS) && (tsel == 2'(k)) && (rsel == 3'd0);
            wr_tl[k] = wr && is_tmr && (k < NUM_TIMERS) && (tsel == 2'(k)) && (rsel == 3'd1);
            wr_tc[k] = wr && is_tmr && (k < NUM_TIMERS) && (tsel == 2'(k)) && (rsel == 3'd2);
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (is_ram) begin
                rdata = ram[ram_idx];
            end else if (is_tmr) begin
                case (rsel)
                    3'd0:    rdata = th[tsel];
                    3'd1:    rdata = tl[tsel];
                    3'd2:    rdata = {28'b0, oneshot[tsel], pend[tsel], ie[tsel], en[tsel]};
                    default: rdata = '0;
                endcase
            end else if (is_io) begin
                case (io_sel)
                    2'd0:    rdata = {24'b0, led};
                    2'd1:    rdata = {24'b0, switch};
                    2'd2:    rdata = {20'b0, digi};
                    default: rdata = 32'(irq_vec);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
            for (int k = 0; k < 4; k++) begin
                th[k] <= '0;
                tl[k] <= '0;
            end
            en       <= '0;
            ie       <= '0;
            pend     <= '0;
            oneshot  <= '0;
            led      <= '0;
            digi     <= '0;
            irqout_q <= 1'b0;
        end else begin
            if (wr && is_ram) ram[ram_idx] <= wdata;
            if (wr && is_io && (io_sel == 2'd0)) led  <= wdata[7:0];
            if (wr && is_io && (io_sel == 2'd2)) digi <= wdata[11:0];
            irqout_q <= irqout;
            // Bus writes override counter activity; an overflow that raises
            // PEND beats a simultaneous write-1-to-clear.
            for (int k = 0; k < 4; k++) begin
                if (wr_th[k]) th[k] <= wdata;
                if (wr_tl[k])   tl[k] <= wdata;
                else if (ovf[k]) tl[k] <= th[k];
                else if (en[k])  tl[k] <= tl[k] + 32'd1;
                if (wr_tc[k])                   en[k] <= wdata[0];
                else if (ovf[k] && oneshot[k]) en[k] <= 1'b0;
                if (wr_tc[k]) begin
                    ie[k]      <= wdata[1];
                    oneshot[k] <= wdata[3];
                end
                if (ovf[k] && ie[k])              pend[k] <= 1'b1;
                else if (wr_tc[k] && wdata[2])    pend[k] <= 1'b0;
            end
        end
    end

    assign irq_vec  = pend[NUM_TIMERS-1:0];
    assign irqout   = |irq_vec;
    assign irq_rise = irqout & ~irqout_q;

endmodule
